// File: rtl/mic_array_capture_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : mic_array_capture_scheduler_if                               |
// | Purpose   : Valid/ready sample stream between the microphone capture     |
// |             scheduler (master) and the audio pipeline (slave).           |
// | Signals   : sample_out        signed sample, SAMPLE_BITS wide            |
// |             channel_out       channel = 2*line + side                    |
// |             sample_valid_out  sample_out/channel_out are valid           |
// |             sample_ready_in   sink accepts when valid && ready           |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface mic_array_capture_scheduler_if #(
   parameter int SAMPLE_BITS = 24,
   parameter int CH_W        = 3
);
   logic [SAMPLE_BITS-1:0] sample_out;
   logic [CH_W-1:0]        channel_out;
   logic                   sample_valid_out;
   logic                   sample_ready_in;

   modport master (
      output sample_out,
      output channel_out,
      output sample_valid_out,
      input  sample_ready_in
   );

   modport slave (
      input  sample_out,
      input  channel_out,
      input  sample_valid_out,
      output sample_ready_in
   );
endinterface
`default_nettype wire

// File: rtl/mic_array_capture_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : mic_array_capture_scheduler                                  |
// | Purpose   : I2S master for a MEMS microphone array. Generates SCK/WS,    |
// |             deserialises NUM_LINES SD lines (L and R mic per line) and   |
// |             drains each completed slot onto one valid/ready stream.      |
// | Ports     : clk_in             system clock                              |
// |             rst_in             asynchronous active-low reset             |
// |             enable_in          run request, honoured at frame boundaries |
// |             mic_sd_in          serial data, bit i = line i               |
// |             mic_sck_out        I2S bit clock                             |
// |             mic_ws_out         word select (0 = left, 1 = right)         |
// |             overflow_out       sticky: undrained words were discarded    |
// |             clear_overflow_in  synchronous clear of overflow_out         |
// |             smp                sample stream (master modport)            |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module mic_array_capture_scheduler #(
   parameter int NUM_LINES   = 4,
   parameter int SCK_DIV     = 16,
   parameter int SAMPLE_BITS = 24,
   parameter int SLOT_BITS   = 32
) (
   input  wire logic                 clk_in,
   input  wire logic                 rst_in,
   input  wire logic                 enable_in,
   input  wire logic [NUM_LINES-1:0] mic_sd_in,
   output logic                      mic_sck_out,
   output logic                      mic_ws_out,
   output logic                      overflow_out,
   input  wire logic                 clear_overflow_in,
   mic_array_capture_scheduler_if.master smp
);
   localparam int CH_W   = $clog2(2*NUM_LINES);
   localparam int DIV_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int BIT_W  = $clog2(2*SLOT_BITS);
   localparam int IDX_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int PEND_W = $clog2(NUM_LINES+1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV-1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*SLOT_BITS-1);
   localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);
   localparam logic [BIT_W-1:0] LAST_SIG = BIT_W'(SAMPLE_BITS);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                                  state_q, state_d;
   logic [DIV_W-1:0]                        div_cnt_q, div_cnt_d;
   logic                                    sck_q, sck_d;
   logic                                    ws_q, ws_d;
   logic [BIT_W-1:0]                        bit_cnt_q, bit_cnt_d;
   logic [NUM_LINES-1:0][SAMPLE_BITS-1:0]   shift_q, shift_d;
   logic [NUM_LINES-1:0][SAMPLE_BITS-1:0]   bank_q, bank_d;
   logic                                    bank_side_q, bank_side_d;
   logic [PEND_W-1:0]                       pending_q, pending_d;
   logic [IDX_W-1:0]                        idx_q, idx_d;
   logic                                    latch_q, latch_d;
   logic                                    valid_q, valid_d;
   logic [SAMPLE_BITS-1:0]                  sample_q, sample_d;
   logic [CH_W-1:0]                         channel_q, channel_d;
   logic                                    overflow_q, overflow_d;

   logic                                    w_sck_rise;
   logic [BIT_W-1:0]                        w_slot_bit;
   logic                                    w_capture;
   logic                                    w_last_bit;
   logic                                    w_xfer;
   logic                                    w_ovf_set;

   // ws_q always equals (bit_cnt_q >= SLOT_BITS), so it selects the slot offset.
   assign w_sck_rise = (state_q == ST_RUN) && (div_cnt_q == DIV_LAST) && !sck_q;
   assign w_slot_bit = ws_q ? (bit_cnt_q - SLOT_LEN) : bit_cnt_q;
   // Slot bit 0 is the I2S one-bit delay; bits past the sample width are padding.
   assign w_capture  = w_sck_rise && (w_slot_bit != '0) && (w_slot_bit <= LAST_SIG);
   assign w_last_bit = w_sck_rise && (w_slot_bit == LAST_SIG);
   assign w_xfer     = valid_q && smp.sample_ready_in;

   // Bit-clock generation and frame sequencing
   always_comb begin : p_fsm
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      sck_d     = sck_q;
      bit_cnt_d = bit_cnt_q;
      ws_d      = ws_q;
      case (state_q)
         ST_IDLE: begin
            if (enable_in) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               sck_d     = ~sck_q;
               if (sck_q) begin
                  // Falling edge: advance the frame position.
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_d = '0;
                     if (!enable_in) begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
                  ws_d = (bit_cnt_d >= SLOT_LEN);
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture, bank latch and drain
   always_comb begin : p_datapath
      shift_d     = shift_q;
      bank_d      = bank_q;
      bank_side_d = bank_side_q;
      pending_d   = pending_q;
      idx_d       = idx_q;
      latch_d     = w_last_bit;
      valid_d     = valid_q;
      sample_d    = sample_q;
      channel_d   = channel_q;
      w_ovf_set   = 1'b0;

      if (w_capture) begin
         for (int l = 0; l < NUM_LINES; l++) begin
            shift_d[l] = {shift_q[l][SAMPLE_BITS-2:0], mic_sd_in[l]};
         end
      end

      if (w_xfer) begin
         valid_d = 1'b0;
      end

      // A latch replaces whatever is left of the old bank; the output
      // register itself is untouched and keeps its word until accepted.
      if (latch_q) begin
         bank_d      = shift_q;
         bank_side_d = ws_q;
         pending_d   = PEND_W'(NUM_LINES);
         idx_d       = '0;
         w_ovf_set   = (pending_q != '0);
      end else if ((!valid_q || w_xfer) && (pending_q != '0)) begin
         sample_d  = bank_q[idx_q];
         channel_d = CH_W'({idx_q, bank_side_q});
         valid_d   = 1'b1;
         pending_d = pending_q - PEND_W'(1);
         idx_d     = idx_q + IDX_W'(1);
      end

      // Set has priority over clear.
      if (w_ovf_set) begin
         overflow_d = 1'b1;
      end else if (clear_overflow_in) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin : p_regs
      if (!rst_in) begin
         state_q     <= ST_IDLE;
         div_cnt_q   <= '0;
         sck_q       <= 1'b0;
         ws_q        <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         bank_q      <= '0;
         bank_side_q <= 1'b0;
         pending_q   <= '0;
         idx_q       <= '0;
         latch_q     <= 1'b0;
         valid_q     <= 1'b0;
         sample_q    <= '0;
         channel_q   <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         sck_q       <= sck_d;
         ws_q        <= ws_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         bank_q      <= bank_d;
         bank_side_q <= bank_side_d;
         pending_q   <= pending_d;
         idx_q       <= idx_d;
         latch_q     <= latch_d;
         valid_q     <= valid_d;
         sample_q    <= sample_d;
         channel_q   <= channel_d;
         overflow_q  <= overflow_d;
      end
   end

   assign mic_sck_out          = sck_q;
   assign mic_ws_out           = ws_q;
   assign overflow_out         = overflow_q;
   assign smp.sample_out       = sample_q;
   assign smp.channel_out      = channel_q;
   assign smp.sample_valid_out = valid_q;

endmodule
`default_nettype wire
